// File: rtl/instruction_encoder_loader.sv
// Packs instruction fields into 16-bit words and streams them
// into instruction memory at consecutive addresses.
module instruction_encoder_loader #(
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              s,
  input  logic [3:0]        OpCode,
  input  logic [3:0]        Rdest,
  input  logic [3:0]        OpCodeExt,
  input  logic [3:0]        Rsrc,
  input  logic [7:0]        imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FINISH
  } state_t;

  state_t state, state_nx;

  logic [15:0]       fifo [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [PW:0]       count;
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] acc_rem;
  logic [ADDR_W-1:0] wr_rem;
  logic [15:0]       word;
  logic              full, empty, push, pop;

  // field packing; the unused fields of each form are dropped
  always_comb begin
    word = {OpCode, Rdest, OpCodeExt, Rsrc};
    if (s) word = {OpCode, Rdest, imm};
  end

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign in_ready = (state == LOAD) & (|acc_rem) & ~full;
  assign mem_we   = (state == LOAD) & ~empty;
  assign mem_data = mem_we ? fifo[rd_ptr] : '0;
  assign mem_addr = wptr;
  assign busy     = (state != IDLE);
  assign push     = in_valid & in_ready;
  assign pop      = mem_we & mem_ready;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) state_nx = (length == '0) ? FINISH : LOAD;
      end
      LOAD: begin
        if (pop && wr_rem == ADDR_W'(1)) state_nx = FINISH;
      end
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // word storage; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= word;
  end

  // fifo pointers, address pointer, remaining counts, done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      wptr    <= '0;
      acc_rem <= '0;
      wr_rem  <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state == FINISH);
      if (state == IDLE && start) begin
        wptr    <= base_addr;
        acc_rem <= length;
        wr_rem  <= length;
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        count   <= '0;
      end else begin
        if (push) begin
          wr_ptr  <= wr_ptr + PW'(1);
          acc_rem <= acc_rem - ADDR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
          wptr   <= wptr + ADDR_W'(1);
          wr_rem <= wr_rem - ADDR_W'(1);
        end
        count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
    end
  end

endmodule
